// File: rtl/calc_stack.sv
// LIFO operand stack: top-of-stack cached in a register, deeper entries in a
// single-port synchronous RAM with a one-cycle refill after a pop.
module calc_stack #(
  parameter int WIDTH     = 32,
  parameter int SIZE_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     in_num,
  output logic [SIZE_BITS-1:0] size,
  output logic [WIDTH-1:0]     top,
  output logic                 error,
  output logic                 out_vld,
  output logic                 dbg_refill
);

  // Command interface: push/pop are single-cycle strobes accepted every cycle;
  // there is no ready. out_vld is low only while a popped top is being refilled.

  localparam logic [SIZE_BITS-1:0] CAP  = '1;
  localparam logic [SIZE_BITS-1:0] ONE  = SIZE_BITS'(1);
  localparam logic [SIZE_BITS-1:0] TWO  = SIZE_BITS'(2);
  localparam int                   DEPTH = 1 << SIZE_BITS;

  typedef enum logic {READY, REFILL} state_t;

  state_t               state_q, state_d;
  logic [SIZE_BITS-1:0] size_q, size_d;
  logic [WIDTH-1:0]     top_q, top_d;
  logic                 error_q, error_d;

  logic                 ram_we, ram_re;
  logic [SIZE_BITS-1:0] ram_addr;
  logic [WIDTH-1:0]     ram_wdata;
  logic [WIDTH-1:0]     ram_rdata_q;
  logic [WIDTH-1:0]     mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    top_d     = top_q;
    error_d   = error_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = size_q - ONE;
    ram_wdata = top_q;

    case (state_q)
      READY: begin
        if (push && pop) begin
          if (size_q == '0) error_d = 1'b1;
          else              top_d   = in_num;
        end else if (push) begin
          if (size_q == CAP) begin
            error_d = 1'b1;
          end else begin
            // Spill the current top into RAM before it is displaced.
            if (size_q != '0) begin
              ram_we   = 1'b1;
              ram_addr = size_q - ONE;
            end
            top_d  = in_num;
            size_d = size_q + ONE;
          end
        end else if (pop) begin
          if (size_q == '0) begin
            error_d = 1'b1;
          end else if (size_q == ONE) begin
            size_d = '0;
            top_d  = '0;
          end else begin
            size_d   = size_q - ONE;
            ram_re   = 1'b1;
            ram_addr = size_q - TWO;
            state_d  = REFILL;
          end
        end
      end

      REFILL: begin
        state_d = READY;
        if (push && pop) begin
          top_d = in_num;
        end else if (push) begin
          // The entry the read was fetching is still in RAM; just drop the data.
          top_d  = in_num;
          if (size_q != CAP) size_d = size_q + ONE;
          else               error_d = 1'b1;
        end else if (pop) begin
          if (size_q >= TWO) begin
            size_d   = size_q - ONE;
            ram_re   = 1'b1;
            ram_addr = size_q - TWO;
            state_d  = REFILL;
          end else if (size_q == ONE) begin
            size_d = '0;
            top_d  = '0;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          top_d = ram_rdata_q;
        end
      end

      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= READY;
      size_q  <= '0;
      top_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      top_q   <= top_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata_q <= mem_q[ram_addr];
  end

  assign size       = size_q;
  assign top        = top_q;
  assign error      = error_q;
  assign out_vld    = (state_q == READY);
  assign dbg_refill = (state_q == REFILL);

endmodule
